// File: rtl/z16_load_store_unit.sv
// Z16 load/store unit: sequences word/byte loads and stores onto a combinational-read data memory.
// Optional macro Z16_LSU_BYTE_EN enables byte accesses (byte stores use a read-modify-write pair).
module z16_load_store_unit (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic        i_req_byte,
   input  logic [15:0] i_req_addr,
   input  logic [15:0] i_req_wdata,
   output logic        o_resp_valid,
   output logic [15:0] o_resp_rdata,
   output logic        o_err,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_wen,
   output logic [15:0] o_mem_wdata,
   input  logic [15:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_STORE     = 3'd2,
      ST_RMW_READ  = 3'd3,
      ST_RMW_WRITE = 3'd4,
      ST_RESP      = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] addr_r;
   logic [15:0] wdata_r;
   logic        we_r;
   logic        byte_r;
   logic [15:0] rdata_r;
   logic        resp_valid_r;
   logic        err_r;
   logic        req_byte_s;
   logic        misaligned_s;
   logic        accept_s;
   logic        ready_s;
   logic [15:0] mem_addr_s;
   logic [15:0] mem_wdata_s;
   logic        mem_wen_s;

   // Selected byte lane of a word, zero-extended; hi selects [15:8].
   function automatic logic [15:0] extract_lane(input logic [15:0] word, input logic hi);
      if (hi) begin
         extract_lane = {8'h00, word[15:8]};
      end else begin
         extract_lane = {8'h00, word[7:0]};
      end
   endfunction

`ifdef Z16_LSU_BYTE_EN
   logic [15:0] merged_r;

   // Word with the selected byte lane replaced by new data.
   function automatic logic [15:0] merge_lane(input logic [15:0] word, input logic [7:0] lane_data,
                                              input logic hi);
      if (hi) begin
         merge_lane = {lane_data, word[7:0]};
      end else begin
         merge_lane = {word[15:8], lane_data};
      end
   endfunction

   assign req_byte_s = i_req_byte;
`else
   logic unused_req_byte_s;

   assign unused_req_byte_s = i_req_byte;
   assign req_byte_s        = 1'b0;
`endif

   assign misaligned_s = i_req_addr[0] & ~req_byte_s;
   assign accept_s     = i_req_valid & ready_s;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and memory-side drive for the current state.
   always_comb begin
      state_next_s = state_r;
      ready_s      = 1'b0;
      mem_addr_s   = 16'h0000;
      mem_wdata_s  = 16'h0000;
      mem_wen_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b1;
            if (i_req_valid) begin
               if (misaligned_s) begin
                  state_next_s = ST_RESP;
               end else if (!i_req_we) begin
                  state_next_s = ST_LOAD;
               end else if (req_byte_s) begin
                  state_next_s = ST_RMW_READ;
               end else begin
                  state_next_s = ST_STORE;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            mem_addr_s   = addr_r;
            state_next_s = ST_RESP;
         end
         ST_STORE: begin
            mem_addr_s   = addr_r;
            mem_wdata_s  = wdata_r;
            mem_wen_s    = 1'b1;
            state_next_s = ST_RESP;
         end
`ifdef Z16_LSU_BYTE_EN
         ST_RMW_READ: begin
            mem_addr_s   = addr_r;
            state_next_s = ST_RMW_WRITE;
         end
         ST_RMW_WRITE: begin
            mem_addr_s   = addr_r;
            mem_wdata_s  = merged_r;
            mem_wen_s    = 1'b1;
            state_next_s = ST_RESP;
         end
`endif
         ST_RESP: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Request capture, load data, and the registered response pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_r       <= 16'h0000;
         wdata_r      <= 16'h0000;
         we_r         <= 1'b0;
         byte_r       <= 1'b0;
         rdata_r      <= 16'h0000;
         resp_valid_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         if (accept_s) begin
            addr_r  <= i_req_addr;
            wdata_r <= i_req_wdata;
            we_r    <= i_req_we;
            byte_r  <= req_byte_s;
         end
         if (state_r == ST_LOAD) begin
            rdata_r <= byte_r ? extract_lane(i_mem_rdata, addr_r[0]) : i_mem_rdata;
         end
         resp_valid_r <= (state_next_s == ST_RESP);
         // Only the IDLE->RESP shortcut is an error completion.
         err_r        <= (state_next_s == ST_RESP) && (state_r == ST_IDLE);
      end
   end

`ifdef Z16_LSU_BYTE_EN
   // Merged word for a byte store, built from the read half of the RMW pair.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         merged_r <= 16'h0000;
      end else if (state_r == ST_RMW_READ) begin
         merged_r <= merge_lane(i_mem_rdata, wdata_r[7:0], addr_r[0]);
      end else begin
         merged_r <= merged_r;
      end
   end
`endif

   assign o_req_ready  = ready_s;
   assign o_resp_valid = resp_valid_r;
   assign o_resp_rdata = rdata_r;
   assign o_err        = err_r;
   assign o_mem_addr   = mem_addr_s;
   assign o_mem_wdata  = mem_wdata_s;
   // A write must never land in a reset cycle, even mid-store.
   assign o_mem_wen    = mem_wen_s & ~i_rst & we_r;

endmodule
